decode_lane_merger: RTL and testbench

Merges the results of N parallel decode lanes, each a set of format-specific decoders, back into a single in-order decoded-instruction stream for the issue stage. Upstream fetch feeds the lanes in strict rotation (lane 0, 1, …, N-1, 0, …), so program order is the rotation order. This block buffers each lane's output in a small FIFO and drains the lanes in the same rotation. Lanes whose decoders rejected an instruction are skipped. Per-lane stalls go back to the decoders, and one downstream stall is honoured.

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_lane_fifo.sv | 71 +++++++
 rtl/decode_lane_merger.sv | 117 +++++++++++
 tb/tb_decode_lane_merger.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode lane merger.
//   - Field widths and bit offsets of the packed decoded-instruction payload
//   - Functional unit identifiers
//   - payload_t: packed view of the payload, MSB-first in field order
package decode_pkg;

    localparam int unsigned OPCODE_W    = 12;
    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned FUNC_UNIT_W = 3;
    localparam int unsigned MAJ_ID_W    = 64;
    localparam int unsigned MIN_ID_W    = 7;
    localparam int unsigned IS64_W      = 1;
    localparam int unsigned PID_W       = 20;
    localparam int unsigned TID_W       = 16;
    localparam int unsigned BODY_W      = 28;

    localparam int unsigned PAYLOAD_W = OPCODE_W + ADDR_W + FUNC_UNIT_W + MAJ_ID_W
                                      + MIN_ID_W + IS64_W + PID_W + TID_W + BODY_W;

    localparam int unsigned BODY_LSB      = 0;
    localparam int unsigned TID_LSB       = BODY_LSB + BODY_W;
    localparam int unsigned PID_LSB       = TID_LSB + TID_W;
    localparam int unsigned IS64_LSB      = PID_LSB + PID_W;
    localparam int unsigned MIN_ID_LSB    = IS64_LSB + IS64_W;
    localparam int unsigned MAJ_ID_LSB    = MIN_ID_LSB + MIN_ID_W;
    localparam int unsigned FUNC_UNIT_LSB = MAJ_ID_LSB + MAJ_ID_W;
    localparam int unsigned ADDR_LSB      = FUNC_UNIT_LSB + FUNC_UNIT_W;
    localparam int unsigned OPCODE_LSB    = ADDR_LSB + ADDR_W;

    typedef enum logic [FUNC_UNIT_W-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_VX     = 3'd2,
        FU_CR     = 3'd3,
        FU_LS     = 3'd4,
        FU_BRANCH = 3'd6
    } func_unit_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   address;
        func_unit_e          funcUnit;
        logic [MAJ_ID_W-1:0] majId;
        logic [MIN_ID_W-1:0] minId;
        logic                is64Bit;
        logic [PID_W-1:0]    pid;
        logic [TID_W-1:0]    tid;
        logic [BODY_W-1:0]   body;
    } payload_t;

endpackage

// File: rtl/decode_lane_fifo.sv
// decode_lane_fifo: single-clock FIFO buffering one decode lane's results.
//   clock_i  rising-edge clock
//   reset_i  asynchronous active-low reset (pointers and count to 0)
//   flush_i  synchronous clear; a same-cycle push is discarded
//   push_i   write data_i (dropped when full unless popping this cycle)
//   pop_i    retire the head entry (ignored when empty)
//   data_i   entry to write
//   head_o   oldest entry
//   count_o  occupancy, 0..depth
//   full_o, empty_o  occupancy flags
module decode_lane_fifo
    import decode_pkg::*;
#(
    parameter int unsigned depth = 4,
    parameter int unsigned width = PAYLOAD_W + 1
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [width-1:0]         data_i,
    output logic [width-1:0]         head_o,
    output logic [$clog2(depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count == (PTR_W+1)'(depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rdPtr];

    assign doPop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (doPush && !flush_i) mem[wrPtr] <= data_i;
    end

endmodule

// File: rtl/decode_lane_merger.sv
// decode_lane_merger: merges N decode lanes back into one in-order stream.
//   clock_i        rising-edge clock
//   reset_i        asynchronous active-low reset
//   flush_i        synchronous flush of all buffered state
//   laneValid_i    lane k produced a decoded instruction
//   laneSkip_i     lane k rejected its instruction (occupies a program-order slot)
//   lanePayload_i  lane k payload at [k*payloadWidth +: payloadWidth]
//   laneStall_o    back-pressure to lane k's decoders
//   stall_i        downstream cannot accept
//   valid_o        payload_o holds a decoded instruction
//   payload_o      registered decoded instruction
module decode_lane_merger
    import decode_pkg::*;
#(
    parameter int unsigned numLanes     = 2,
    parameter int unsigned fifoDepth    = 4,
    parameter int unsigned payloadWidth = PAYLOAD_W
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             flush_i,
    input  logic [numLanes-1:0]              laneValid_i,
    input  logic [numLanes-1:0]              laneSkip_i,
    input  logic [numLanes*payloadWidth-1:0] lanePayload_i,
    output logic [numLanes-1:0]              laneStall_o,
    input  logic                             stall_i,
    output logic                             valid_o,
    output logic [payloadWidth-1:0]          payload_o
);

    localparam int unsigned RR_W  = (numLanes > 1) ? $clog2(numLanes) : 1;
    localparam int unsigned CNT_W = $clog2(fifoDepth) + 1;

    logic [RR_W-1:0]         rrPtr;
    logic [RR_W-1:0]         rrNext;
    logic [CNT_W-1:0]        laneCount [numLanes];
    logic [payloadWidth:0]   laneHead  [numLanes];
    logic [numLanes-1:0]     laneEmpty;
    logic [numLanes-1:0]     laneFull;
    logic [numLanes-1:0]     lanePush;
    logic [numLanes-1:0]     lanePop;
    logic                    load;
    logic                    headEmpty;
    logic                    headSkip;
    logic [payloadWidth-1:0] headPayload;

    assign load   = !valid_o || !stall_i;
    assign rrNext = (rrPtr == RR_W'(numLanes - 1)) ? '0 : rrPtr + 1'b1;

    for (genvar k = 0; k < numLanes; k++) begin : g_lane
        // Entry = {skip, payload}; valid wins when both strobes are set.
        logic [payloadWidth:0] pushData;

        assign pushData    = {laneSkip_i[k] && !laneValid_i[k],
                              lanePayload_i[k*payloadWidth +: payloadWidth]};
        assign lanePush[k] = laneValid_i[k] || laneSkip_i[k];
        assign lanePop[k]  = load && !flush_i && (rrPtr == RR_W'(k));
        assign laneStall_o[k] = (laneCount[k] >= CNT_W'(fifoDepth - 1));

        decode_lane_fifo #(
            .depth (fifoDepth),
            .width (payloadWidth + 1)
        ) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .flush_i (flush_i),
            .push_i  (lanePush[k]),
            .pop_i   (lanePop[k]),
            .data_i  (pushData),
            .head_o  (laneHead[k]),
            .count_o (laneCount[k]),
            .full_o  (laneFull[k]),
            .empty_o (laneEmpty[k])
        );

        always_ff @(posedge clock_i) begin
            if (reset_i && !flush_i) begin
                assert (!(laneValid_i[k] && laneSkip_i[k]))
                    else $error("lane %0d: valid and skip asserted together", k);
                assert (!(lanePush[k] && laneFull[k] && !lanePop[k]))
                    else $error("lane %0d: push into full FIFO dropped", k);
            end
        end
    end

    always_comb begin
        headEmpty   = 1'b1;
        headSkip    = 1'b0;
        headPayload = '0;
        for (int unsigned k = 0; k < numLanes; k++) begin
            if (rrPtr == RR_W'(k)) begin
                headEmpty = laneEmpty[k];
                {headSkip, headPayload} = laneHead[k];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o   <= 1'b0;
            payload_o <= '0;
            rrPtr     <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            rrPtr   <= '0;
        end else if (load) begin
            if (headEmpty) begin
                valid_o <= 1'b0;
            end else begin
                rrPtr   <= rrNext;
                valid_o <= !headSkip;
                if (!headSkip) payload_o <= headPayload;
            end
        end
    end

endmodule

// File: tb/tb_decode_lane_merger.sv
// tb_decode_lane_merger: directed self-checking bench for decode_lane_merger
// (2 lanes, depth 4). Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point.
module tb_decode_lane_merger;
    import decode_pkg::*;

    localparam int unsigned NL = 2;

    logic                     clock_i = 1'b0;
    logic                     reset_i = 1'b0;
    logic                     flush_i = 1'b0;
    logic [NL-1:0]            laneValid_i = '0;
    logic [NL-1:0]            laneSkip_i = '0;
    logic [NL*PAYLOAD_W-1:0]  lanePayload_i = '0;
    logic [NL-1:0]            laneStall_o;
    logic                     stall_i = 1'b0;
    logic                     valid_o;
    logic [PAYLOAD_W-1:0]     payload_o;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    decode_lane_merger #(
        .numLanes     (NL),
        .fifoDepth    (4),
        .payloadWidth (PAYLOAD_W)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .laneValid_i   (laneValid_i),
        .laneSkip_i    (laneSkip_i),
        .lanePayload_i (lanePayload_i),
        .laneStall_o   (laneStall_o),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .payload_o     (payload_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic payload_t mk(input int unsigned id);
        payload_t p;
        p          = '0;
        p.majId    = 64'(id);
        p.opcode   = 12'(id);
        p.address  = 64'h1000 + 64'(id * 4);
        p.funcUnit = FU_LS;
        p.tid      = 16'(id ^ 32'h5a5a);
        p.body     = 28'(id * 3);
        return p;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        laneValid_i = '0;
        laneSkip_i  = '0;
    endtask

    task automatic push(input int unsigned k, input int unsigned id);
        laneValid_i[k] = 1'b1;
        lanePayload_i[k*PAYLOAD_W +: PAYLOAD_W] = mk(id);
    endtask

    task automatic expect_out(input string tag, input int unsigned id);
        check({tag, "_valid"}, valid_o, 1'b1);
        check({tag, "_payload"}, payload_o, mk(id));
    endtask

    initial begin
        // reset state
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_payload", payload_o, '0);
        check("rst_lanestall", laneStall_o, 2'b00);
        tick();
        tick();
        reset_i = 1'b1;
        check("rst_rr", dut.rrPtr, 1'b0);

        // ordered merge: 10,11,12,13
        push(0, 10); push(1, 11);
        tick();
        check("merge_latency", valid_o, 1'b0);
        push(0, 12); push(1, 13);
        tick();
        expect_out("merge0", 10);
        idle();
        tick(); expect_out("merge1", 11);
        tick(); expect_out("merge2", 12);
        tick(); expect_out("merge3", 13);
        tick();
        check("merge_drain", valid_o, 1'b0);
        check("merge_rr", dut.rrPtr, 1'b0);

        // skip: 20, bubble, 22
        push(0, 20); laneSkip_i[1] = 1'b1;
        lanePayload_i[PAYLOAD_W +: PAYLOAD_W] = mk(99);
        tick();
        check("skip_lat", valid_o, 1'b0);
        idle(); push(0, 22);
        tick(); expect_out("skip0", 20);
        idle();
        tick(); check("skip_bubble", valid_o, 1'b0);
        tick(); expect_out("skip2", 22);
        check("skip_rr", dut.rrPtr, 1'b1);
        tick(); check("skip_drain", valid_o, 1'b0);

        // flush with 3 buffered entries and valid_o high (rrPtr starts at 1)
        stall_i = 1'b1;
        push(0, 31); push(1, 30);
        tick(); check("flush_pre0", valid_o, 1'b0);
        push(0, 33); push(1, 32);
        tick(); expect_out("flush_pre1", 30);
        idle(); push(0, 34); flush_i = 1'b1;
        tick();
        check("flush_valid", valid_o, 1'b0);
        check("flush_rr", dut.rrPtr, 1'b0);
        check("flush_cnt0", dut.laneCount[0], '0);
        check("flush_cnt1", dut.laneCount[1], '0);
        check("flush_lanestall", laneStall_o, 2'b00);
        flush_i = 1'b0; idle(); stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_post", valid_o, 1'b0);
        end

        // lane starvation: lane 1 waits for lane 0
        push(1, 40);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("starve_valid", valid_o, 1'b0);
            check("starve_rr", dut.rrPtr, 1'b0);
            tick();
        end
        push(0, 41);
        tick(); check("starve_lat", valid_o, 1'b0);
        idle();
        tick(); expect_out("starve0", 41);
        tick(); expect_out("starve1", 40);
        tick(); check("starve_drain", valid_o, 1'b0);

        // back-pressure: decoders see laneStall_o with one cycle of latency
        stall_i = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] expStall;
            idle();
            if (e <= 5) push(0, 100 + 2 * (e - 1));
            if (e <= 4) push(1, 101 + 2 * (e - 1));
            tick();
            expStall = (e <= 2) ? 2'b00 : (e == 3) ? 2'b10 : 2'b11;
            check($sformatf("bp_lanestall_e%0d", e), laneStall_o, expStall);
            if (e == 1) check("bp_first_lat", valid_o, 1'b0);
            else expect_out($sformatf("bp_hold_e%0d", e), 100);
        end
        idle(); stall_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            expect_out($sformatf("bp_drain%0d", i), 100 + i);
        end
        tick();
        check("bp_empty", valid_o, 1'b0);
        check("bp_lanestall_end", laneStall_o, 2'b00);

        // async reset mid-stream (rrPtr is 1 here)
        stall_i = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            idle();
            push(0, 60 + 2 * (e - 1));
            push(1, 61 + 2 * (e - 1));
            tick();
        end
        idle();
        expect_out("ar_pre", 61);
        check("ar_pre_lanestall", laneStall_o, 2'b01);
        #2;
        reset_i = 1'b0;
        #1;
        check("ar_valid", valid_o, 1'b0);
        check("ar_payload", payload_o, '0);
        check("ar_lanestall", laneStall_o, 2'b00);
        tick();
        check("ar_hold_valid", valid_o, 1'b0);
        reset_i = 1'b1; stall_i = 1'b0;
        check("ar_rr", dut.rrPtr, 1'b0);
        push(0, 70);
        tick(); check("ar_post_lat", valid_o, 1'b0);
        idle();
        tick(); expect_out("ar_post", 70);
        tick(); check("ar_post_drain", valid_o, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
